neuron_sweep_scheduler: RTL and testbench
=========================================

Name: neuron_sweep_scheduler

Overview:
- Time-multiplexed controller for the leaky integrate-and-fire neuron datapath. It holds NUM_NEURONS 8-bit membrane potentials in an internal array.
- During the integrate phase it accepts weighted input events through a valid/ready handshake.
- On each timestep tick it sweeps every neuron: applies leak, checks thresholds, resets potentials and emits spikes through a valid/ready output.
- It sits between the axon event router and the spike output queue of a neuromorphic core.

Parameters:
- NUM_NEURONS, 16, number of neurons in the potential array; power of two, 2..256.
- IDX_W, $clog2(NUM_NEURONS), width of neuron index ports.
- REFRACT_TICKS, 2, refractory length in ticks; used only with NEURON_REFRACTORY_EN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- enable_i  in  1  when 0: no events accepted, tick_i ignored; a sweep already in progress completes.
- tick_i  in  1  timestep strobe, 1-cycle pulse.
- event_valid_i  in  1  input event valid.
- event_ready_o  out  1  input event ready.
- event_neuron_i  in  IDX_W  target neuron of the event.
- event_wsel_i  in  2  weight select: 0→weight_type1_i, 1→weight_type2_i, 2→weight_type3_i, 3→weight_type4_i.
- weight_type1_i..weight_type4_i  in  8 each  unsigned synaptic weights.
- leak_value_i  in  8  leak subtracted per tick.
- pos_threshold_i  in  8  positive firing threshold.
- neg_threshold_i  in  8  negative threshold; 0 disables negative spikes.
- pos_reset_i  in  8  potential loaded after a positive spike.
- neg_reset_i  in  8  potential loaded after a negative spike.
- spike_valid_o  out  1  spike output valid.
- spike_ready_i  in  1  spike output ready.
- spike_neuron_o  out  IDX_W  index of the spiking neuron.
- spike_neg_o  out  1  1 = negative spike, 0 = positive spike.
- busy_o  out  1  high while a sweep is in progress.
- done_o  out  1  1-cycle pulse at the end of a sweep.
- overrun_o  out  1  sticky; set when tick_i arrives while busy_o=1.
- dbg_addr_i  in  IDX_W  debug read index.
- dbg_potential_o  out  8  combinational read of potential[dbg_addr_i].

Behaviour:
- Reset (synchronous): all potentials=0; state=IDLE; all outputs 0; overrun_o=0; sweep index=0.
- FSM states are IDLE, LEAK, SPIKE, DONE.
- IDLE:
  - event_ready_o = enable_i.
  - On event handshake: potential[n] = min(potential[n] + weight, 255), 9-bit add with saturation; written at that clock edge.
  - At most one event per cycle.
  - event_neuron_i is always in range because the index is power-of-two sized.
- tick_i in IDLE with enable_i=1 → LEAK with idx=0 next cycle.
  - An event handshaking in the same cycle is applied before the sweep.
  - event_ready_o=0 in every state other than IDLE.
- LEAK: one cycle per neuron.
  - p = max(potential[idx] - leak_value_i, 0), floor at 0.
  - If p >= pos_threshold_i: positive spike, write pos_reset_i.
  - Else if neg_threshold_i != 0 and p < neg_threshold_i: negative spike, write neg_reset_i.
  - Else write p.
  - Positive has priority over negative.
  - On spike → SPIKE. Otherwise idx+1 → LEAK, or DONE if idx = NUM_NEURONS-1.
- SPIKE:
  - spike_valid_o=1; spike_neuron_o and spike_neg_o held stable until spike_ready_i=1.
  - On handshake → next neuron or DONE, as in LEAK.
  - spike_valid_o is never dropped without a handshake.
- DONE: done_o=1 for one cycle, then IDLE.
- Timing:
  - busy_o=1 in LEAK, SPIKE and DONE.
  - With tick accepted at cycle T, k spikes and spike_ready_i held high, done_o is high at T+1+NUM_NEURONS+k.
- tick_i while busy_o=1 is ignored and sets overrun_o; it clears only on reset.
- Deassertion of enable_i mid-sweep does not abort the sweep.
- Reset mid-sweep returns to IDLE, clears potentials and drops any pending spike.
- Config inputs are sampled live and must be held stable during a sweep.

Optional Feature:
- NEURON_REFRACTORY_EN defined:
  - Each neuron gets a counter of width $clog2(REFRACT_TICKS+1), loaded with REFRACT_TICKS on any spike.
  - While counter != 0, events to that neuron are accepted but discarded.
  - In LEAK, such a neuron skips leak and threshold checks, keeps its potential, and its counter decrements.
- Undefined: no counters; every event is integrated.

Test Plan:
- Reset → all potentials 0; spike_valid_o, busy_o, done_o, overrun_o = 0; event_ready_o=1 with enable_i=1.
- Weights 10/20/30/40; three events neuron 1 wsel=3; neuron 2 wsel=0 → dbg reads 120 and 10.
- Repeat event neuron 1 wsel=3 ×7 → saturates at 255.
- NUM_NEURONS=4, leak 5, pos_thr 100, pos_reset 20, neg_thr 0:
  - Potentials {0,120,10,0}; tick with ready=1 → single spike neuron 1, spike_neg_o=0.
  - Potentials {0,20,5,0}; done_o at T+6.
- neg_thr 8, neg_reset 50, potential[2]=10, leak 5 → p=5 < 8 → negative spike idx 2, potential 50.
- Spike back-pressure: hold spike_ready_i=0 10 cycles → spike outputs stable.
  - tick during this window → overrun_o=1; extra tick dropped.
- With NEURON_REFRACTORY_EN, REFRACT_TICKS=2:
  - After neuron 1 spikes, events to it are ignored for the next 2 ticks.
  - Integration resumes on tick 3.

Source files
------------

// File: rtl/neuron_sweep_scheduler.sv
// Time-multiplexed LIF neuron scheduler: integrates weighted events, sweeps leak/threshold per tick.
// Optional refractory counters per neuron when NEURON_REFRACTORY_EN is defined.
module neuron_sweep_scheduler #(
  parameter int NUM_NEURONS   = 16,
  parameter int IDX_W         = $clog2(NUM_NEURONS),
  parameter int REFRACT_TICKS = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             tick_i,
  input  logic             event_valid_i,
  output logic             event_ready_o,
  input  logic [IDX_W-1:0] event_neuron_i,
  input  logic [1:0]       event_wsel_i,
  input  logic [7:0]       weight_type1_i,
  input  logic [7:0]       weight_type2_i,
  input  logic [7:0]       weight_type3_i,
  input  logic [7:0]       weight_type4_i,
  input  logic [7:0]       leak_value_i,
  input  logic [7:0]       pos_threshold_i,
  input  logic [7:0]       neg_threshold_i,
  input  logic [7:0]       pos_reset_i,
  input  logic [7:0]       neg_reset_i,
  output logic             spike_valid_o,
  input  logic             spike_ready_i,
  output logic [IDX_W-1:0] spike_neuron_o,
  output logic             spike_neg_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overrun_o,
  input  logic [IDX_W-1:0] dbg_addr_i,
  output logic [7:0]       dbg_potential_o
);

  typedef enum logic [1:0] {S_IDLE, S_LEAK, S_SPIKE, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_pot [NUM_NEURONS];
  logic             r_spike_neg;
  logic             r_overrun;

  logic             w_evt_fire;
  logic             w_evt_drop;
  logic [7:0]       w_weight;
  logic [8:0]       w_evt_sum;
  logic [7:0]       w_evt_sat;
  logic [7:0]       w_cur;
  logic [8:0]       w_leak_diff;
  logic [7:0]       w_p;
  logic             w_skip;
  logic             w_pos_spk;
  logic             w_neg_spk;
  logic             w_spk;
  logic             w_last;
  logic [7:0]       w_leak_wdata;

  always_comb begin
    w_weight = weight_type1_i;
    case (event_wsel_i)
      2'd0:    w_weight = weight_type1_i;
      2'd1:    w_weight = weight_type2_i;
      2'd2:    w_weight = weight_type3_i;
      default: w_weight = weight_type4_i;
    endcase
  end

  assign w_evt_fire = (r_state == S_IDLE) && enable_i && event_valid_i;
  assign w_evt_sum  = {1'b0, r_pot[event_neuron_i]} + {1'b0, w_weight};
  assign w_evt_sat  = w_evt_sum[8] ? 8'hFF : w_evt_sum[7:0];

  // Leak floors at zero; the borrow bit of the 9-bit difference flags underflow.
  assign w_cur        = r_pot[r_idx];
  assign w_leak_diff  = {1'b0, w_cur} - {1'b0, leak_value_i};
  assign w_p          = w_leak_diff[8] ? 8'd0 : w_leak_diff[7:0];
  assign w_pos_spk    = !w_skip && (w_p >= pos_threshold_i);
  assign w_neg_spk    = !w_skip && !w_pos_spk && (neg_threshold_i != 8'd0) && (w_p < neg_threshold_i);
  assign w_spk        = w_pos_spk || w_neg_spk;
  assign w_last       = (r_idx == IDX_W'(NUM_NEURONS - 1));
  assign w_leak_wdata = w_skip    ? w_cur       :
                        w_pos_spk ? pos_reset_i :
                        w_neg_spk ? neg_reset_i : w_p;

`ifdef NEURON_REFRACTORY_EN
  localparam int REF_W = (REFRACT_TICKS < 1) ? 1 : $clog2(REFRACT_TICKS + 1);

  logic [REF_W-1:0] r_refr [NUM_NEURONS];

  assign w_skip     = (r_refr[r_idx] != '0);
  assign w_evt_drop = (r_refr[event_neuron_i] != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_refr[i] <= '0;
    end else if (r_state == S_LEAK) begin
      if (w_skip)
        r_refr[r_idx] <= r_refr[r_idx] - REF_W'(1);
      else if (w_spk)
        r_refr[r_idx] <= REF_W'(REFRACT_TICKS);
    end
  end
`else
  assign w_skip     = (REFRACT_TICKS < 0);
  assign w_evt_drop = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    event_ready_o = 1'b0;
    spike_valid_o = 1'b0;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o        = 1'b0;
        event_ready_o = enable_i;
        if (enable_i && tick_i) w_state_nxt = S_LEAK;
      end
      S_LEAK: begin
        if (w_spk)       w_state_nxt = S_SPIKE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_SPIKE: begin
        spike_valid_o = 1'b1;
        if (spike_ready_i) w_state_nxt = w_last ? S_DONE : S_LEAK;
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Index wraps to 0 after the last neuron since the array size is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx       <= '0;
      r_spike_neg <= 1'b0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) r_pot[i] <= 8'd0;
    end else begin
      if (tick_i && (r_state != S_IDLE)) r_overrun <= 1'b1;
      if (w_evt_fire && !w_evt_drop) r_pot[event_neuron_i] <= w_evt_sat;
      if (r_state == S_LEAK) begin
        r_pot[r_idx] <= w_leak_wdata;
        if (w_spk) r_spike_neg <= w_neg_spk;
        else       r_idx       <= r_idx + IDX_W'(1);
      end
      if ((r_state == S_SPIKE) && spike_ready_i) r_idx <= r_idx + IDX_W'(1);
    end
  end

  assign spike_neuron_o  = r_idx;
  assign spike_neg_o     = r_spike_neg;
  assign overrun_o       = r_overrun;
  assign dbg_potential_o = r_pot[dbg_addr_i];

endmodule

// File: tb/tb_neuron_sweep_scheduler.sv
// Randomized bench for neuron_sweep_scheduler against a transaction-level neuron model.
module tb_neuron_sweep_scheduler;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int RT = 2;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          enable_i = 1'b1;
  logic          tick_i = 1'b0;
  logic          event_valid_i = 1'b0;
  logic          event_ready_o;
  logic [IW-1:0] event_neuron_i = '0;
  logic [1:0]    event_wsel_i = '0;
  logic [7:0]    wt [4];
  logic [7:0]    leak = 8'd0, pos_thr = 8'd255, neg_thr = 8'd0, pos_rst = 8'd0, neg_rst = 8'd0;
  logic          spike_valid_o;
  logic          spike_ready_i = 1'b1;
  logic [IW-1:0] spike_neuron_o;
  logic          spike_neg_o;
  logic          busy_o, done_o, overrun_o;
  logic [IW-1:0] dbg_addr_i = '0;
  logic [7:0]    dbg_potential_o;

  always #5 clk = ~clk;

  neuron_sweep_scheduler #(.NUM_NEURONS(N), .IDX_W(IW), .REFRACT_TICKS(RT)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .tick_i(tick_i),
    .event_valid_i(event_valid_i), .event_ready_o(event_ready_o),
    .event_neuron_i(event_neuron_i), .event_wsel_i(event_wsel_i),
    .weight_type1_i(wt[0]), .weight_type2_i(wt[1]), .weight_type3_i(wt[2]), .weight_type4_i(wt[3]),
    .leak_value_i(leak), .pos_threshold_i(pos_thr), .neg_threshold_i(neg_thr),
    .pos_reset_i(pos_rst), .neg_reset_i(neg_rst),
    .spike_valid_o(spike_valid_o), .spike_ready_i(spike_ready_i),
    .spike_neuron_o(spike_neuron_o), .spike_neg_o(spike_neg_o),
    .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o),
    .dbg_addr_i(dbg_addr_i), .dbg_potential_o(dbg_potential_o)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mpot [N];
  int mrefr [N];
  int moverrun = 0;
  int exp_spk [$];
  int exp_done_cyc = 0;
  bit chk_time = 1'b0;
  int done_seen = 0;
  bit prev_vld = 1'b0, prev_rdy = 1'b0, prev_neg = 1'b0;
  int prev_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected effect of one tick: leak, threshold and reset over every neuron in index order.
  task automatic model_sweep(output int k);
    k = 0;
    for (int i = 0; i < N; i++) begin
      int p;
`ifdef NEURON_REFRACTORY_EN
      if (mrefr[i] != 0) begin
        mrefr[i]--;
        continue;
      end
`endif
      p = mpot[i] - int'(leak);
      if (p < 0) p = 0;
      if (p >= int'(pos_thr)) begin
        exp_spk.push_back(i * 2);
        mpot[i] = int'(pos_rst);
        mrefr[i] = RT;
        k++;
      end else if (neg_thr != 0 && p < int'(neg_thr)) begin
        exp_spk.push_back(i * 2 + 1);
        mpot[i] = int'(neg_rst);
        mrefr[i] = RT;
        k++;
      end else begin
        mpot[i] = p;
      end
    end
  endtask

  task automatic model_event(input int n, input int ws);
`ifdef NEURON_REFRACTORY_EN
    if (mrefr[n] != 0) return;
`endif
    mpot[n] = mpot[n] + int'(wt[ws]);
    if (mpot[n] > 255) mpot[n] = 255;
  endtask

  task automatic send_event(input int n, input int ws, input bit en);
    event_valid_i  = 1'b1;
    event_neuron_i = IW'(n);
    event_wsel_i   = 2'(ws);
    enable_i       = en;
    #1;
    chk("evt_ready", int'(event_ready_o), int'(en));
    if (en) model_event(n, ws);
    step();
    event_valid_i = 1'b0;
    enable_i      = 1'b1;
  endtask

  task automatic check_pots(input string name);
    for (int i = 0; i < N; i++) begin
      dbg_addr_i = IW'(i);
      #1;
      chk(name, int'(dbg_potential_o), mpot[i]);
    end
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 2000 && done_seen == d0; i++) begin
      step();
      if (!chk_time && spike_valid_o === 1'b0) spike_ready_i = 1'($urandom_range(0, 1));
    end
    chk("sweep_done_timeout", int'(done_seen != d0), 1);
    spike_ready_i = 1'b1;
  endtask

  // Launch a sweep; with steady ready the done cycle is checked against T+1+N+k.
  task automatic run_sweep(input bit rand_rdy, output int k);
    int d0;
    model_sweep(k);
    d0            = done_seen;
    exp_done_cyc  = cyc + 1 + N + k;
    chk_time      = !rand_rdy;
    tick_i        = 1'b1;
    enable_i      = 1'b1;
    spike_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    step();
    tick_i = 1'b0;
    if (rand_rdy) begin
      for (int i = 0; i < 2000 && done_seen == d0; i++) begin
        spike_ready_i  = 1'($urandom_range(0, 1));
        event_valid_i  = 1'($urandom_range(0, 1));
        event_neuron_i = IW'($urandom_range(0, N - 1));
        step();
      end
      event_valid_i = 1'b0;
    end
    wait_done(d0);
  endtask

  always @(negedge clk) begin
    if (rst_i) begin
      prev_vld = 1'b0;
    end else begin
      if (prev_vld && !prev_rdy) begin
        chk("spk_hold_vld", int'(spike_valid_o), 1);
        chk("spk_hold_idx", int'(spike_neuron_o), prev_idx);
        chk("spk_hold_neg", int'(spike_neg_o), int'(prev_neg));
      end
      if (spike_valid_o && spike_ready_i) begin
        if (exp_spk.size() == 0) begin
          chk("spk_unexpected", int'(spike_neuron_o), -1);
        end else begin
          int e;
          e = exp_spk.pop_front();
          chk("spk_idx", int'(spike_neuron_o), e / 2);
          chk("spk_neg", int'(spike_neg_o), e % 2);
        end
      end
      if (busy_o && event_valid_i) chk("evt_ready_busy", int'(event_ready_o), 0);
      if (done_o) begin
        done_seen++;
        chk("done_spk_left", exp_spk.size(), 0);
        if (chk_time) chk("done_time", cyc, exp_done_cyc);
      end
      prev_vld = spike_valid_o;
      prev_rdy = spike_ready_i;
      prev_idx = int'(spike_neuron_o);
      prev_neg = spike_neg_o;
    end
  end

  initial begin
    int k;
    int t0;
    int d0;
    wt[0] = 8'd10; wt[1] = 8'd20; wt[2] = 8'd30; wt[3] = 8'd40;
    for (int i = 0; i < N; i++) begin
      mpot[i]  = 0;
      mrefr[i] = 0;
    end
    repeat (3) step();
    rst_i = 1'b0;
    #1;
    chk("rst_spike_valid", int'(spike_valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_overrun", int'(overrun_o), 0);
    chk("rst_ready", int'(event_ready_o), 1);
    check_pots("rst_pot");

    repeat (3) send_event(1, 3, 1'b1);
    send_event(2, 0, 1'b1);
    dbg_addr_i = IW'(1); #1; chk("lit_pot1_120", int'(dbg_potential_o), 120);
    dbg_addr_i = IW'(2); #1; chk("lit_pot2_10", int'(dbg_potential_o), 10);

    leak = 8'd5; pos_thr = 8'd100; pos_rst = 8'd20; neg_thr = 8'd0; neg_rst = 8'd0;
    t0 = cyc;
    run_sweep(1'b0, k);
    chk("lit_first_k", k, 1);
    chk("lit_first_done_ofs", exp_done_cyc - t0, 6);
    check_pots("sweep1_pot");
    dbg_addr_i = IW'(2); #1; chk("lit_pot2_5", int'(dbg_potential_o), 5);

    repeat (7) send_event(1, 3, 1'b1);
`ifndef NEURON_REFRACTORY_EN
    dbg_addr_i = IW'(1); #1; chk("lit_sat_255", int'(dbg_potential_o), 255);
`endif
    wt[0] = 8'd5;
    send_event(2, 0, 1'b1);
    send_event(3, 0, 1'b0);
    neg_thr = 8'd8; neg_rst = 8'd50;
    run_sweep(1'b0, k);
    check_pots("neg_pot");
`ifndef NEURON_REFRACTORY_EN
    chk("lit_neg_k", k, 4);
    dbg_addr_i = IW'(2); #1; chk("lit_neg_pot2_50", int'(dbg_potential_o), 50);
`endif

    pos_thr = 8'd40;
    model_sweep(k);
    d0       = done_seen;
    chk_time = 1'b0;
    tick_i   = 1'b1;
    spike_ready_i = 1'b0;
    step();
    tick_i = 1'b0;
    if (k != 0) begin
      for (int i = 0; i < 20 && !spike_valid_o; i++) step();
      chk("bp_valid", int'(spike_valid_o), 1);
      for (int i = 0; i < 10; i++) begin
        tick_i = (i == 3);
        if (i == 3) moverrun = 1;
        step();
      end
      tick_i = 1'b0;
      chk("lit_overrun", int'(overrun_o), 1);
    end
    spike_ready_i = 1'b1;
    wait_done(d0);
    step(); step();
    chk("bp_no_extra_sweep", int'(busy_o), 0);
    check_pots("bp_pot");

    for (int it = 0; it < 40; it++) begin
      int ne;
      for (int j = 0; j < 4; j++) wt[j] = 8'($urandom_range(0, 120));
      leak    = 8'($urandom_range(0, 40));
      pos_thr = 8'($urandom_range(60, 255));
      neg_thr = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 30));
      pos_rst = 8'($urandom_range(0, 80));
      neg_rst = 8'($urandom_range(0, 80));
      ne = $urandom_range(0, 8);
      for (int j = 0; j < ne; j++)
        send_event($urandom_range(0, N - 1), $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 4) == 0) begin
        enable_i = 1'b0;
        tick_i   = 1'b1;
        step();
        tick_i   = 1'b0;
        enable_i = 1'b1;
        chk("tick_disabled", int'(busy_o), 0);
      end
      check_pots("rand_pre_pot");
      run_sweep(it[0], k);
      check_pots("rand_post_pot");
    end
    chk("overrun_sticky", int'(overrun_o), moverrun);

    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    spike_ready_i = 1'b0;
    step(); step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    spike_ready_i = 1'b1;
    exp_spk.delete();
    moverrun = 0;
    for (int i = 0; i < N; i++) begin
      mpot[i]  = 0;
      mrefr[i] = 0;
    end
    #1;
    chk("rst_mid_busy", int'(busy_o), 0);
    chk("rst_mid_valid", int'(spike_valid_o), 0);
    chk("rst_mid_overrun", int'(overrun_o), moverrun);
    check_pots("rst_mid_pot");
    send_event(0, 1, 1'b1);
    check_pots("post_rst_pot");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
